// File: rtl/axi_dac_pkg.sv
// -----------------------------------------------------------------------------
// axi_dac_pkg
// Shared definitions for the processor-bus aggregator (axi_dac_up_aggr) and
// its ack-combine helper.
//   up_state_e        : aggregator FSM states (IDLE, WAIT_W, WAIT_R)
//   UP_TIMEOUT_DATA   : read data returned when a slave never answers
//   UP_ERR_CNT_WIDTH  : width of the saturating error counter
// -----------------------------------------------------------------------------
package axi_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_W = 2'd1,
    ST_WAIT_R = 2'd2
  } up_state_e;

  localparam logic [31:0] UP_TIMEOUT_DATA  = 32'hDEAD_DEAD;
  localparam int          UP_ERR_CNT_WIDTH = 16;

endpackage

// File: rtl/axi_dac_up_ack_combine.sv
// -----------------------------------------------------------------------------
// axi_dac_up_ack_combine
// Reduces the per-slave ack vector of the transaction currently in flight.
//   ack_i   : one ack bit per slave (already filtered to the right type)
//   data_i  : flattened slave read data, slave i in bits [32i+31:32i]
//   any_o   : at least one slave acked
//   multi_o : more than one slave acked in the same cycle
//   data_o  : OR of the data words of the acking slaves only
// -----------------------------------------------------------------------------
module axi_dac_up_ack_combine #(
  parameter int NUM_SLAVES = 4
) (
  input  logic [NUM_SLAVES-1:0]    ack_i,
  input  logic [32*NUM_SLAVES-1:0] data_i,
  output logic                     any_o,
  output logic                     multi_o,
  output logic [31:0]              data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (ack_i[i]) data_o = data_o | data_i[32*i +: 32];
    end
  end

  assign any_o   = |ack_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(ack_i & (ack_i - NUM_SLAVES'(1)));

endmodule

// File: rtl/axi_dac_up_aggr.sv
// -----------------------------------------------------------------------------
// axi_dac_up_aggr
// Fans one processor register master out to NUM_SLAVES register slaves and
// folds their acks back into a single response. One transaction is in flight
// at a time; one further request can wait in a single pending slot.
//
// Ports (all in the up_clk domain, up_rstn async active-low):
//   up_wreq/up_waddr/up_wdata, up_rreq/up_raddr : master requests
//   up_wack, up_rack/up_rdata                   : master responses
//   s_wreq/s_waddr/s_wdata, s_rreq/s_raddr      : broadcast slave requests
//   s_wack, s_rack/s_rdata                      : per-slave responses
//   up_err/up_err_count                         : error pulse, saturating count
//
// Build option: define AXI_DAC_UP_AGGR_TIMEOUT_EN to complete a transaction
// after TIMEOUT_CYCLES cycles without an ack (read data UP_TIMEOUT_DATA, error
// flagged). Without it the FSM waits for an ack indefinitely.
// -----------------------------------------------------------------------------
module axi_dac_up_aggr
  import axi_dac_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        up_clk,
  input  logic                        up_rstn,
  input  logic                        up_wreq,
  input  logic [ADDR_WIDTH-1:0]       up_waddr,
  input  logic [31:0]                 up_wdata,
  output logic                        up_wack,
  input  logic                        up_rreq,
  input  logic [ADDR_WIDTH-1:0]       up_raddr,
  output logic                        up_rack,
  output logic [31:0]                 up_rdata,
  output logic [NUM_SLAVES-1:0]       s_wreq,
  output logic [ADDR_WIDTH-1:0]       s_waddr,
  output logic [31:0]                 s_wdata,
  input  logic [NUM_SLAVES-1:0]       s_wack,
  output logic [NUM_SLAVES-1:0]       s_rreq,
  output logic [ADDR_WIDTH-1:0]       s_raddr,
  input  logic [NUM_SLAVES-1:0]       s_rack,
  input  logic [32*NUM_SLAVES-1:0]    s_rdata,
  output logic                        up_err,
  output logic [UP_ERR_CNT_WIDTH-1:0] up_err_count
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("axi_dac_up_aggr: NUM_SLAVES or TIMEOUT_CYCLES out of range");
  end

  up_state_e                   state_q, state_d;
  logic                        pend_valid_q, pend_valid_d;
  logic                        pend_write_q, pend_write_d;
  logic [ADDR_WIDTH-1:0]       pend_addr_q, pend_addr_d;
  logic [31:0]                 pend_data_q, pend_data_d;
  logic                        s_wreq_q, s_wreq_d;
  logic                        s_rreq_q, s_rreq_d;
  logic [ADDR_WIDTH-1:0]       s_waddr_q, s_waddr_d;
  logic [ADDR_WIDTH-1:0]       s_raddr_q, s_raddr_d;
  logic [31:0]                 s_wdata_q, s_wdata_d;
  logic                        up_wack_q, up_wack_d;
  logic                        up_rack_q, up_rack_d;
  logic [31:0]                 up_rdata_q, up_rdata_d;
  logic                        up_err_q, up_err_d;
  logic [UP_ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic                        took_w, took_r, drop, multi_hit, timeout;
  logic [NUM_SLAVES-1:0]       ack_sel;
  logic                        ack_any, ack_multi;
  logic [31:0]                 ack_data;
  logic                        to_hit;

  // Only acks of the type the FSM is waiting for are seen; everything else,
  // including any ack while idle, is dropped here.
  always_comb begin
    ack_sel = '0;
    if (state_q == ST_WAIT_W) ack_sel = s_wack;
    if (state_q == ST_WAIT_R) ack_sel = s_rack;
  end

  axi_dac_up_ack_combine #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_ack_combine (
    .ack_i   (ack_sel),
    .data_i  (s_rdata),
    .any_o   (ack_any),
    .multi_o (ack_multi),
    .data_o  (ack_data)
  );

`ifdef AXI_DAC_UP_AGGR_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q, to_cnt_d;

  // Zero in the cycle the slave request is on the bus, so the last cycle an
  // ack can still arrive is the one where the count reaches TIMEOUT_CYCLES-1.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (s_wreq_d || s_rreq_d)    to_cnt_d = '0;
    else if (state_q != ST_IDLE) to_cnt_d = to_cnt_q + 16'd1;
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end

  assign to_hit = (to_cnt_q == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_write_d = pend_write_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    s_wreq_d     = 1'b0;
    s_rreq_d     = 1'b0;
    s_waddr_d    = s_waddr_q;
    s_raddr_d    = s_raddr_q;
    s_wdata_d    = s_wdata_q;
    up_wack_d    = 1'b0;
    up_rack_d    = 1'b0;
    up_rdata_d   = '0;
    took_w       = 1'b0;
    took_r       = 1'b0;
    drop         = 1'b0;
    multi_hit    = 1'b0;
    timeout      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A waiting request always goes before anything new from the master.
        if (pend_valid_q) begin
          pend_valid_d = 1'b0;
          if (pend_write_q) begin
            s_wreq_d  = 1'b1;
            s_waddr_d = pend_addr_q;
            s_wdata_d = pend_data_q;
            state_d   = ST_WAIT_W;
          end else begin
            s_rreq_d  = 1'b1;
            s_raddr_d = pend_addr_q;
            state_d   = ST_WAIT_R;
          end
        end else if (up_wreq) begin
          took_w    = 1'b1;
          s_wreq_d  = 1'b1;
          s_waddr_d = up_waddr;
          s_wdata_d = up_wdata;
          state_d   = ST_WAIT_W;
        end else if (up_rreq) begin
          took_r    = 1'b1;
          s_rreq_d  = 1'b1;
          s_raddr_d = up_raddr;
          state_d   = ST_WAIT_R;
        end
      end
      ST_WAIT_W: begin
        if (ack_any) begin
          up_wack_d = 1'b1;
          multi_hit = ack_multi;
          state_d   = ST_IDLE;
        end else if (to_hit) begin
          up_wack_d = 1'b1;
          timeout   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_R: begin
        if (ack_any) begin
          up_rack_d  = 1'b1;
          up_rdata_d = ack_data;
          multi_hit  = ack_multi;
          state_d    = ST_IDLE;
        end else if (to_hit) begin
          up_rack_d  = 1'b1;
          up_rdata_d = UP_TIMEOUT_DATA;
          timeout    = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests not issued this cycle compete for the slot, write first. The
    // slot counts as free if the pending entry was just issued.
    if (up_wreq && !took_w) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_write_d = 1'b1;
        pend_addr_d  = up_waddr;
        pend_data_d  = up_wdata;
      end else begin
        drop = 1'b1;
      end
    end
    if (up_rreq && !took_r) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_write_d = 1'b0;
        pend_addr_d  = up_raddr;
        pend_data_d  = '0;
      end else begin
        drop = 1'b1;
      end
    end

    // Several error causes in one cycle still count once.
    up_err_d  = drop | multi_hit | timeout;
    err_cnt_d = err_cnt_q;
    if (up_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + UP_ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_write_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      s_wreq_q     <= 1'b0;
      s_rreq_q     <= 1'b0;
      s_waddr_q    <= '0;
      s_raddr_q    <= '0;
      s_wdata_q    <= '0;
      up_wack_q    <= 1'b0;
      up_rack_q    <= 1'b0;
      up_rdata_q   <= '0;
      up_err_q     <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_write_q <= pend_write_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      s_wreq_q     <= s_wreq_d;
      s_rreq_q     <= s_rreq_d;
      s_waddr_q    <= s_waddr_d;
      s_raddr_q    <= s_raddr_d;
      s_wdata_q    <= s_wdata_d;
      up_wack_q    <= up_wack_d;
      up_rack_q    <= up_rack_d;
      up_rdata_q   <= up_rdata_d;
      up_err_q     <= up_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign s_wreq       = {NUM_SLAVES{s_wreq_q}};
  assign s_rreq       = {NUM_SLAVES{s_rreq_q}};
  assign s_waddr      = s_waddr_q;
  assign s_raddr      = s_raddr_q;
  assign s_wdata      = s_wdata_q;
  assign up_wack      = up_wack_q;
  assign up_rack      = up_rack_q;
  assign up_rdata     = up_rdata_q;
  assign up_err       = up_err_q;
  assign up_err_count = err_cnt_q;

endmodule
